// File: rtl/tp_probe_mux.sv
// Run-time selectable test-point driver.
// One probe bank is routed to the test points in one of four modes: OFF,
// LIVE, STRETCH (per-bit pulse stretching) or HOLD (trigger-armed snapshot).
//
// HOLD sub-FSM:
//   state    | meaning
//   ST_IDLE  | showing live data, waiting for ARM
//   ST_ARMED | showing live data, next registered trigger captures
//   ST_HELD  | showing the captured word, HELD asserted
module tp_probe_mux #(
  parameter int NBANKS  = 4,
  parameter int WIDTH   = 16,
  parameter int SELW    = 2,
  parameter int STRETCH = 8
) (
  input  logic                     CLK,
  input  logic                     RST_B,
  input  logic [NBANKS*WIDTH-1:0]  PROBES,
  input  logic                     CFG_WE,
  input  logic [SELW+1:0]          CFG_DATA,
  input  logic                     TRIG,
  input  logic                     ARM,
  output logic [WIDTH-1:0]         TP_OUT,
  output logic [WIDTH-1:0]         TP_DIR,
  output logic                     HELD,
  output logic [SELW+1:0]          CFG_RBK
);

  localparam int CW = $clog2(STRETCH + 1);
  localparam logic [CW-1:0] RELOAD = CW'(STRETCH - 1);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_LIVE    = 2'b01,
    MODE_STRETCH = 2'b10,
    MODE_HOLD    = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_HELD  = 2'b10
  } hold_state_t;

  logic [NBANKS*WIDTH-1:0] s_q;
  logic                    t_q;
  logic [SELW-1:0]         bank_q;
  mode_t                   mode_q;
  hold_state_t             state_q;
  hold_state_t             state_d;
  logic                    capture;
  logic [WIDTH-1:0]        cap_q;
  logic [CW-1:0]           cnt_q [WIDTH];
  logic [CW-1:0]           cnt_d [WIDTH];
  logic [WIDTH-1:0]        sel_word;
  logic [WIDTH-1:0]        stretch_word;
  logic [WIDTH-1:0]        tp_d;
  logic                    cfg_ok;

  // Writes naming a bank that does not exist are dropped completely.
  assign cfg_ok = CFG_WE && (int'(CFG_DATA[SELW-1:0]) < NBANKS);

  // Select the configured bank out of the registered probe bus.
  always_comb begin
    sel_word = '0;
    for (int b = 0; b < NBANKS; b++) begin
      if (bank_q == SELW'(b)) begin
        sel_word = s_q[b*WIDTH +: WIDTH];
      end
    end
  end

  // Per-bit stretch: a high bit reloads its counter, otherwise it drains.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      stretch_word[i] = sel_word[i] | (cnt_q[i] != '0);
      cnt_d[i] = '0;
      if (!cfg_ok && mode_q == MODE_STRETCH) begin
        if (sel_word[i]) begin
          cnt_d[i] = RELOAD;
        end else if (cnt_q[i] != '0) begin
          cnt_d[i] = cnt_q[i] - 1'b1;
        end
      end
    end
  end

  // HOLD next-state; any accepted write or leaving HOLD parks the FSM in IDLE.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    if (cfg_ok || mode_q != MODE_HOLD) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ARM) state_d = ST_ARMED;
        end
        ST_ARMED: begin
          // trigger takes priority over a simultaneous ARM
          if (t_q) begin
            state_d = ST_HELD;
            capture = 1'b1;
          end
        end
        ST_HELD: begin
          if (ARM) state_d = ST_ARMED;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output word per mode; on the capture edge the live word equals the captured one.
  always_comb begin
    tp_d = '0;
    case (mode_q)
      MODE_OFF:     tp_d = '0;
      MODE_LIVE:    tp_d = sel_word;
      MODE_STRETCH: tp_d = stretch_word;
      MODE_HOLD:    tp_d = (state_q == ST_HELD && state_d == ST_HELD) ? cap_q : sel_word;
      default:      tp_d = '0;
    endcase
  end

  // Input stage: probes and trigger registered together.
  always_ff @(posedge CLK) begin
    if (!RST_B) begin
      s_q <= '0;
      t_q <= 1'b0;
    end else begin
      s_q <= PROBES;
      t_q <= TRIG;
    end
  end

  // Configuration registers.
  always_ff @(posedge CLK) begin
    if (!RST_B) begin
      bank_q <= '0;
      mode_q <= MODE_OFF;
    end else if (cfg_ok) begin
      bank_q <= CFG_DATA[SELW-1:0];
      mode_q <= mode_t'(CFG_DATA[SELW+1:SELW]);
    end
  end

  // Stretch counters, HOLD state and capture register.
  always_ff @(posedge CLK) begin
    if (!RST_B) begin
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      state_q <= ST_IDLE;
      cap_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      if (capture) cap_q <= sel_word;
    end
  end

  // Output registers; direction and readback follow the mode in force one edge later.
  always_ff @(posedge CLK) begin
    if (!RST_B) begin
      TP_OUT  <= '0;
      TP_DIR  <= '1;
      CFG_RBK <= '0;
    end else begin
      TP_OUT  <= tp_d;
      TP_DIR  <= (mode_q == MODE_OFF) ? '1 : '0;
      CFG_RBK <= {mode_q, bank_q};
    end
  end

  assign HELD = (state_q == ST_HELD);

endmodule

// File: tb/tb_tp_probe_mux.sv
// Bench for tp_probe_mux with NBANKS=4, WIDTH=16, SELW=3, STRETCH=8.
module tb_tp_probe_mux;

  localparam int NB = 4;
  localparam int W  = 16;
  localparam int SW = 3;
  localparam int ST = 8;

  logic            CLK = 1'b0;
  logic            RST_B;
  logic [NB*W-1:0] PROBES;
  logic            CFG_WE;
  logic [SW+1:0]   CFG_DATA;
  logic            TRIG;
  logic            ARM;
  logic [W-1:0]    TP_OUT;
  logic [W-1:0]    TP_DIR;
  logic            HELD;
  logic [SW+1:0]   CFG_RBK;

  int checks = 0;
  int failures = 0;

  tp_probe_mux #(.NBANKS(NB), .WIDTH(W), .SELW(SW), .STRETCH(ST)) dut (
    .CLK(CLK), .RST_B(RST_B), .PROBES(PROBES), .CFG_WE(CFG_WE),
    .CFG_DATA(CFG_DATA), .TRIG(TRIG), .ARM(ARM), .TP_OUT(TP_OUT),
    .TP_DIR(TP_DIR), .HELD(HELD), .CFG_RBK(CFG_RBK)
  );

  always #5 CLK = ~CLK;

  // Reference model: timestamps of last high bit for stretching, flags for hold.
  logic [NB*W-1:0] m_s;
  logic            m_t;
  int              m_mode, m_bank, edge_n;
  int              last_hi [W];
  bit              m_armed, m_frozen;
  logic [W-1:0]    m_cap;
  logic [W-1:0]    e_out, e_dir;
  logic [SW+1:0]   e_rbk;
  logic            e_held;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [W-1:0] word, o;
    bit valid;
    if (!RST_B) begin
      m_s = '0; m_t = 1'b0; m_mode = 0; m_bank = 0;
      m_armed = 0; m_frozen = 0;
      for (int i = 0; i < W; i++) last_hi[i] = -1000;
      e_out = '0; e_dir = '1; e_rbk = '0; e_held = 1'b0;
    end else begin
      word  = m_s[m_bank*W +: W];
      valid = CFG_WE && (int'(CFG_DATA[SW-1:0]) < NB);
      o = '0;
      case (m_mode)
        1: o = word;
        2: for (int i = 0; i < W; i++)
             o[i] = word[i] || (edge_n - last_hi[i] < ST);
        3: begin
          if (valid) begin
            m_armed = 0; m_frozen = 0; o = word;
          end else if (m_frozen) begin
            if (ARM) begin m_frozen = 0; m_armed = 1; o = word; end
            else o = m_cap;
          end else if (m_armed) begin
            if (m_t) begin m_frozen = 1; m_armed = 0; m_cap = word; end
            o = word;
          end else begin
            m_armed = ARM; o = word;
          end
        end
        default: o = '0;
      endcase
      if (m_mode != 3) begin m_armed = 0; m_frozen = 0; end
      if (m_mode == 2 && !valid) begin
        for (int i = 0; i < W; i++) if (word[i]) last_hi[i] = edge_n;
      end else begin
        for (int i = 0; i < W; i++) last_hi[i] = -1000;
      end
      e_out  = o;
      e_dir  = (m_mode == 0) ? '1 : '0;
      e_rbk  = {2'(m_mode), 3'(m_bank)};
      e_held = m_frozen;
      if (valid) begin
        m_mode = int'(CFG_DATA[SW+1:SW]);
        m_bank = int'(CFG_DATA[SW-1:0]);
      end
      m_s = PROBES;
      m_t = TRIG;
    end
    edge_n++;
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
    check("tp_out", 32'(TP_OUT), 32'(e_out));
    check("tp_dir", 32'(TP_DIR), 32'(e_dir));
    check("held", 32'(HELD), 32'(e_held));
    check("cfg_rbk", 32'(CFG_RBK), 32'(e_rbk));
  endtask

  task automatic write_cfg(input logic [1:0] mode, input logic [SW-1:0] bank);
    CFG_WE = 1'b1; CFG_DATA = {mode, bank};
    tick();
    CFG_WE = 1'b0;
  endtask

  initial begin
    int hi_cnt, rises;
    logic prev;
    edge_n = 0;
    RST_B = 1'b0; PROBES = '0; CFG_WE = 1'b0; CFG_DATA = '0; TRIG = 1'b0; ARM = 1'b0;
    #2;
    tick(); tick();
    check("reset_tp_dir", 32'(TP_DIR), 32'hFFFF);
    RST_B = 1'b1;

    // OFF mode with toggling probes
    for (int i = 0; i < 6; i++) begin
      PROBES = {$urandom, $urandom};
      tick();
      check("off_tp_out", 32'(TP_OUT), 32'h0);
      check("off_rbk", 32'(CFG_RBK), 32'h0);
    end

    // LIVE on bank 2
    PROBES = '0;
    write_cfg(2'b01, 3'd2);
    PROBES[2*W +: W] = 16'hA5C3;
    tick(); tick();
    check("live_a5c3", 32'(TP_OUT), 32'hA5C3);
    check("live_dir", 32'(TP_DIR), 32'h0);

    // out-of-range bank is ignored
    write_cfg(2'b10, 3'd5);
    tick();
    check("bad_bank_rbk", 32'(CFG_RBK), 32'b01010);
    check("bad_bank_out", 32'(TP_OUT), 32'hA5C3);

    // random LIVE traffic with occasional bank changes
    for (int i = 0; i < 30; i++) begin
      PROBES = {$urandom, $urandom};
      if ($urandom_range(0, 4) == 0) begin
        CFG_WE = 1'b1; CFG_DATA = {2'b01, 3'($urandom_range(0, 7))};
      end
      tick();
      CFG_WE = 1'b0;
    end

    // STRETCH: single pulse on bit 0 -> 8 high cycles
    PROBES = '0;
    write_cfg(2'b10, 3'd0);
    tick(); tick();
    hi_cnt = 0;
    PROBES[0] = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      PROBES[0] = 1'b0;
      hi_cnt += int'(TP_OUT[0]);
    end
    check("stretch_pulse_len", 32'(hi_cnt), 32'd8);

    // two pulses 3 cycles apart -> one continuous 11-cycle high
    hi_cnt = 0; rises = 0; prev = 1'b0;
    for (int i = 0; i < 20; i++) begin
      PROBES[0] = (i == 0 || i == 3);
      tick();
      hi_cnt += int'(TP_OUT[0]);
      if (TP_OUT[0] && !prev) rises++;
      prev = TP_OUT[0];
    end
    check("stretch_retrig_len", 32'(hi_cnt), 32'd11);
    check("stretch_retrig_rises", 32'(rises), 32'd1);

    // random sparse STRETCH traffic
    for (int i = 0; i < 40; i++) begin
      PROBES = {$urandom & $urandom & $urandom, $urandom & $urandom & $urandom};
      tick();
    end

    // HOLD: arm, count on bank 1, trigger at 7
    PROBES = '0;
    write_cfg(2'b11, 3'd1);
    ARM = 1'b1; tick(); ARM = 1'b0;
    for (int c = 0; c < 10; c++) begin
      PROBES[W +: W] = 16'(c);
      TRIG = (c == 7);
      tick();
    end
    TRIG = 1'b0;
    check("hold_freeze", 32'(TP_OUT), 32'h0007);
    check("hold_held", 32'(HELD), 32'd1);
    PROBES[W +: W] = 16'h0020; TRIG = 1'b1; tick(); TRIG = 1'b0; tick();
    check("hold_retrig_ignored", 32'(TP_OUT), 32'h0007);
    ARM = 1'b1; tick(); ARM = 1'b0;
    check("hold_release", 32'(HELD), 32'd0);
    tick();
    check("hold_live_again", 32'(TP_OUT), 32'h0020);

    // ARM+TRIG in ARMED captures; ARM+TRIG in HELD re-arms
    PROBES[W +: W] = 16'h1234;
    ARM = 1'b1; TRIG = 1'b1;
    tick(); tick();
    check("armed_arm_trig_held", 32'(HELD), 32'd1);
    PROBES[W +: W] = 16'h5678;
    tick();
    check("held_arm_trig_rearm", 32'(HELD), 32'd0);
    ARM = 1'b0; TRIG = 1'b0;
    tick(); tick();
    // config write while held
    write_cfg(2'b11, 3'd1);
    check("cfg_clears_held", 32'(HELD), 32'd0);
    PROBES[W +: W] = 16'h9ABC;
    tick(); tick();
    check("cfg_live_resumes", 32'(TP_OUT), 32'h9ABC);

    // random HOLD traffic
    for (int i = 0; i < 60; i++) begin
      PROBES = {$urandom, $urandom};
      ARM  = ($urandom_range(0, 5) == 0);
      TRIG = ($urandom_range(0, 3) == 0);
      tick();
    end
    ARM = 1'b0; TRIG = 1'b0;

    // fully random: writes (valid or not), resets, arm, trig
    for (int i = 0; i < 300; i++) begin
      PROBES = ($urandom_range(0, 1) == 0) ? {$urandom, $urandom}
                                           : {$urandom & $urandom, $urandom & $urandom};
      CFG_WE   = ($urandom_range(0, 9) == 0);
      CFG_DATA = 5'($urandom);
      ARM      = ($urandom_range(0, 6) == 0);
      TRIG     = ($urandom_range(0, 2) == 0);
      RST_B    = ($urandom_range(0, 60) != 0);
      tick();
    end
    CFG_WE = 1'b0; ARM = 1'b0; TRIG = 1'b0; RST_B = 1'b1;

    // reset mid-count in STRETCH
    PROBES = '0;
    write_cfg(2'b10, 3'd3);
    PROBES[3*W +: W] = 16'hFFFF;
    tick(); PROBES = '0; tick(); tick();
    check("pre_reset_stretch", 32'(TP_OUT), 32'hFFFF);
    RST_B = 1'b0; tick(); RST_B = 1'b1;
    check("mid_reset_out", 32'(TP_OUT), 32'h0);
    check("mid_reset_dir", 32'(TP_DIR), 32'hFFFF);
    check("mid_reset_rbk", 32'(CFG_RBK), 32'h0);
    write_cfg(2'b10, 3'd3);
    tick(); tick();
    check("post_reset_cnt_clear", 32'(TP_OUT), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
